leaf_mem_arbiter: RTL and testbench

Shares the leaf memory (NUM_LEAVES leaves × LEAF_SIZE patch RAMs) between one leaf loader (write port) and NUM_REQ k-NN search lanes (read ports). Each cycle it grants at most one access, drives the leaf memory's SRAM-style control pins, and routes read data back to the requesting lane with its ID after a fixed memory latency. It sits in `top` between the search lanes and the leaf memory instance.

---
 rtl/leaf_mem_pkg.sv | 23 ++
 rtl/rr_arbiter.sv | 29 ++
 rtl/leaf_mem_arbiter.sv | 135 +++++++++++++
 tb/tb_leaf_mem_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/leaf_mem_pkg.sv
// Shared geometry and types for the k-NN leaf memory and its arbiter.
package leaf_mem_pkg;

    localparam int unsigned DATA_WIDTH = 11;
    localparam int unsigned PATCH_SIZE = 5;
    localparam int unsigned LEAF_SIZE  = 8;
    localparam int unsigned NUM_LEAVES = 64;
    localparam int unsigned ADDR_WIDTH = $clog2(NUM_LEAVES);
    localparam int unsigned SLOT_WIDTH = $clog2(LEAF_SIZE);

    typedef logic [DATA_WIDTH-1:0] elem_t;
    typedef elem_t [PATCH_SIZE-1:0] patch_t;
    typedef patch_t [LEAF_SIZE-1:0] leaf_t;
    typedef logic [ADDR_WIDTH-1:0] leaf_addr_t;

    // Kind of memory access granted in the current cycle.
    typedef enum logic [1:0] {
        AccIdle  = 2'd0,
        AccRead  = 2'd1,
        AccWrite = 2'd2
    } access_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: searches from ptr_i+1 upward (wrapping) for the first request.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    localparam int unsigned IDX_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0]   req_i,
    input  logic [IDX_WIDTH-1:0] ptr_i,
    output logic [NUM_REQ-1:0]   gnt_o,
    output logic [IDX_WIDTH-1:0] idx_o
);

    always_comb begin
        logic                 found;
        logic [IDX_WIDTH-1:0] cand;
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_WIDTH'((32'(ptr_i) + k) % NUM_REQ);
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

endmodule

// File: rtl/leaf_mem_arbiter.sv
// Shares the leaf memory between the leaf loader (write, top priority) and the search lanes
// (round-robin reads), returning read data tagged with the requesting lane.
module leaf_mem_arbiter #(
    parameter int unsigned DATA_WIDTH   = leaf_mem_pkg::DATA_WIDTH,
    parameter int unsigned PATCH_SIZE   = leaf_mem_pkg::PATCH_SIZE,
    parameter int unsigned LEAF_SIZE    = leaf_mem_pkg::LEAF_SIZE,
    parameter int unsigned NUM_LEAVES   = leaf_mem_pkg::NUM_LEAVES,
    parameter int unsigned ADDR_WIDTH   = $clog2(NUM_LEAVES),
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned READ_LATENCY = 1,
    localparam int unsigned SLOT_WIDTH  = (LEAF_SIZE > 1) ? $clog2(LEAF_SIZE) : 1,
    localparam int unsigned ID_WIDTH    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int unsigned PATCH_BITS  = PATCH_SIZE * DATA_WIDTH,
    localparam int unsigned LEAF_BITS   = LEAF_SIZE * PATCH_BITS
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            rd_req,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_REQ-1:0]            rd_gnt,
    input  logic                          wr_req,
    input  logic [ADDR_WIDTH-1:0]         wr_addr,
    input  logic [SLOT_WIDTH-1:0]         wr_slot,
    input  logic [PATCH_BITS-1:0]         wr_data,
    output logic                          wr_gnt,
    output logic                          mem_csb,
    output logic                          mem_web,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic [LEAF_SIZE-1:0]          mem_wmask,
    output logic [PATCH_BITS-1:0]         mem_wdata,
    input  logic [LEAF_BITS-1:0]          mem_rdata,
    output logic                          rsp_valid,
    output logic [ID_WIDTH-1:0]           rsp_id,
    output logic [LEAF_BITS-1:0]          rsp_data
);

    import leaf_mem_pkg::*;

    logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0]    arb_gnt;
    logic [ID_WIDTH-1:0]   arb_idx;
    logic [ADDR_WIDTH-1:0] lane_addr [NUM_REQ];
    logic                  rd_fire;
    access_e               access;

    logic [READ_LATENCY-1:0]               pipe_vld_q;
    logic [READ_LATENCY-1:0][ID_WIDTH-1:0] pipe_id_q;
    logic                                  rsp_valid_q;
    logic [ID_WIDTH-1:0]                   rsp_id_q;
    logic [LEAF_BITS-1:0]                  rsp_data_q;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane_addr
        assign lane_addr[g] = rd_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req_i (rd_req),
        .ptr_i (rr_ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx)
    );

    always_comb begin
        if (wr_req) begin
            access = AccWrite;
        end else if (|rd_req) begin
            access = AccRead;
        end else begin
            access = AccIdle;
        end
    end

    assign mem_wdata = wr_data;

    always_comb begin
        wr_gnt    = 1'b0;
        rd_gnt    = '0;
        mem_csb   = 1'b1;
        mem_web   = 1'b1;
        mem_addr  = '0;
        mem_wmask = '0;
        rr_ptr_d  = rr_ptr_q;
        rd_fire   = 1'b0;
        unique case (access)
            AccWrite: begin
                // Writes never move the round-robin pointer.
                wr_gnt    = 1'b1;
                mem_csb   = 1'b0;
                mem_web   = 1'b0;
                mem_addr  = wr_addr;
                mem_wmask = LEAF_SIZE'(1) << wr_slot;
            end
            AccRead: begin
                rd_gnt   = arb_gnt;
                mem_csb  = 1'b0;
                mem_addr = lane_addr[arb_idx];
                rr_ptr_d = arb_idx;
                rd_fire  = 1'b1;
            end
            default: ;
        endcase
    end

    // The pipe mirrors the memory's read latency; the response registers add one more stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q    <= ID_WIDTH'(NUM_REQ - 1);
            pipe_vld_q  <= '0;
            pipe_id_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
        end else begin
            rr_ptr_q      <= rr_ptr_d;
            pipe_vld_q[0] <= rd_fire;
            pipe_id_q[0]  <= rd_fire ? arb_idx : '0;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1];
                pipe_id_q[i]  <= pipe_id_q[i-1];
            end
            rsp_valid_q <= pipe_vld_q[READ_LATENCY-1];
            rsp_id_q    <= pipe_id_q[READ_LATENCY-1];
            if (pipe_vld_q[READ_LATENCY-1]) begin
                rsp_data_q <= mem_rdata;
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_leaf_mem_arbiter.sv
// Bench for leaf_mem_arbiter: a READ_LATENCY=1 and a READ_LATENCY=2 instance share stimulus,
// each backed by its own read pipe on a common behavioural SRAM, checked against a request-level model.
module tb_leaf_mem_arbiter;

    import leaf_mem_pkg::*;

    localparam int NR = 4;
    localparam int AW = ADDR_WIDTH;
    localparam int PW = DATA_WIDTH;
    localparam int PB = PATCH_SIZE * DATA_WIDTH;
    localparam int LB = LEAF_SIZE * PB;

    typedef struct {
        int            due;
        int            id;
        logic [LB-1:0] data;
    } rsp_t;

    logic              clk;
    logic              rst_n;
    logic [NR-1:0]     rd_req;
    logic [NR*AW-1:0]  rd_addr;
    logic              wr_req;
    logic [AW-1:0]     wr_addr;
    logic [2:0]        wr_slot;
    logic [PB-1:0]     wr_data;

    logic [NR-1:0]     a_rd_gnt, b_rd_gnt;
    logic              a_wr_gnt, b_wr_gnt;
    logic              a_csb, a_web, b_csb, b_web;
    logic [AW-1:0]     a_addr, b_addr;
    logic [LEAF_SIZE-1:0] a_wmask, b_wmask;
    logic [PB-1:0]     a_wdata, b_wdata;
    logic [LB-1:0]     a_rdata, b_rdata;
    logic              a_rsp_valid, b_rsp_valid;
    logic [1:0]        a_rsp_id, b_rsp_id;
    logic [LB-1:0]     a_rsp_data, b_rsp_data;

    leaf_mem_arbiter dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_gnt    (a_rd_gnt),
        .wr_req    (wr_req),
        .wr_addr   (wr_addr),
        .wr_slot   (wr_slot),
        .wr_data   (wr_data),
        .wr_gnt    (a_wr_gnt),
        .mem_csb   (a_csb),
        .mem_web   (a_web),
        .mem_addr  (a_addr),
        .mem_wmask (a_wmask),
        .mem_wdata (a_wdata),
        .mem_rdata (a_rdata),
        .rsp_valid (a_rsp_valid),
        .rsp_id    (a_rsp_id),
        .rsp_data  (a_rsp_data)
    );

    leaf_mem_arbiter #(
        .READ_LATENCY (2)
    ) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_gnt    (b_rd_gnt),
        .wr_req    (wr_req),
        .wr_addr   (wr_addr),
        .wr_slot   (wr_slot),
        .wr_data   (wr_data),
        .wr_gnt    (b_wr_gnt),
        .mem_csb   (b_csb),
        .mem_web   (b_web),
        .mem_addr  (b_addr),
        .mem_wmask (b_wmask),
        .mem_wdata (b_wdata),
        .mem_rdata (b_rdata),
        .rsp_valid (b_rsp_valid),
        .rsp_id    (b_rsp_id),
        .rsp_data  (b_rsp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [LB-1:0] seed_leaf(input int l);
        logic [LB-1:0] r;
        for (int s = 0; s < LEAF_SIZE; s++)
            for (int e = 0; e < PATCH_SIZE; e++)
                r[(s*PATCH_SIZE+e)*PW +: PW] = PW'((l*37 + s*11 + e*5 + 3) % 2048);
        return r;
    endfunction

    function automatic logic [LB-1:0] rand_leaf();
        logic [LB-1:0] r;
        for (int i = 0; i < LB/8; i++) r[i*8 +: 8] = 8'($urandom);
        return r;
    endfunction

    function automatic logic [PB-1:0] rand_patch();
        logic [PB-1:0] r;
        for (int e = 0; e < PATCH_SIZE; e++) r[e*PW +: PW] = PW'($urandom);
        return r;
    endfunction

    // Behavioural SRAM: writes from dut_a's pins; unread cycles return garbage on rdata.
    logic [LB-1:0] sram [NUM_LEAVES];
    logic          loaded = 1'b0;
    logic [LB-1:0] rdb1_q;
    always @(posedge clk) begin
        if (!loaded) begin
            for (int l = 0; l < NUM_LEAVES; l++) sram[l] <= seed_leaf(l);
            loaded <= 1'b1;
        end else if (!a_csb && !a_web) begin
            for (int s = 0; s < LEAF_SIZE; s++)
                if (a_wmask[s]) sram[a_addr][s*PB +: PB] <= a_wdata;
        end
        a_rdata <= (!a_csb && a_web) ? sram[a_addr] : rand_leaf();
        rdb1_q  <= (!b_csb && b_web) ? sram[b_addr] : rand_leaf();
        b_rdata <= rdb1_q;
    end

    // Reference model state.
    logic [LB-1:0] shadow [NUM_LEAVES];
    rsp_t          qa[$];
    rsp_t          qb[$];
    logic [LB-1:0] last_a, last_b;
    int            ptr;
    int            cyc;
    int            last_win;
    int            checks = 0;
    int            errors = 0;

    task automatic chk(input string tag, input logic [LB-1:0] obs, input logic [LB-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        qa.delete();
        qb.delete();
        last_a = '0;
        last_b = '0;
        ptr    = NR - 1;
    endtask

    // Called at posedge+1; async reset pulse that is over before the next edge.
    task automatic reset_pulse();
        rst_n = 1'b0;
        #1;
        chk("rst_a_valid", LB'(a_rsp_valid), LB'(0));
        chk("rst_a_id", LB'(a_rsp_id), LB'(0));
        chk("rst_a_data", a_rsp_data, '0);
        chk("rst_b_valid", LB'(b_rsp_valid), LB'(0));
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic do_cycle(input bit drop);
        int            win;
        logic [AW-1:0] raddr;
        @(negedge clk);
        win = -1;
        if (!wr_req)
            for (int k = 1; k <= NR; k++)
                if (win < 0 && rd_req[(ptr + k) % NR]) win = (ptr + k) % NR;
        chk("wr_gnt", LB'(a_wr_gnt), LB'(wr_req));
        chk("rd_gnt", LB'(a_rd_gnt), (win >= 0) ? (LB'(1) << win) : LB'(0));
        chk("b_rd_gnt", LB'(b_rd_gnt), (win >= 0) ? (LB'(1) << win) : LB'(0));
        chk("mem_csb", LB'(a_csb), LB'(!(wr_req || win >= 0)));
        chk("mem_web", LB'(a_web), LB'(!wr_req));
        chk("mem_wmask", LB'(a_wmask), wr_req ? (LB'(1) << wr_slot) : LB'(0));
        raddr = (win >= 0) ? rd_addr[win*AW +: AW] : '0;
        if (wr_req) begin
            chk("mem_addr_wr", LB'(a_addr), LB'(wr_addr));
            chk("mem_wdata", LB'(a_wdata), LB'(wr_data));
        end else if (win >= 0) begin
            chk("mem_addr_rd", LB'(a_addr), LB'(raddr));
        end
        if (qa.size() > 0 && qa[0].due == cyc) begin
            chk("a_rsp_valid", LB'(a_rsp_valid), LB'(1));
            chk("a_rsp_id", LB'(a_rsp_id), LB'(qa[0].id));
            chk("a_rsp_data", a_rsp_data, qa[0].data);
            last_a = qa[0].data;
            void'(qa.pop_front());
        end else begin
            chk("a_rsp_idle", LB'(a_rsp_valid), LB'(0));
            chk("a_rsp_hold", a_rsp_data, last_a);
        end
        if (qb.size() > 0 && qb[0].due == cyc) begin
            chk("b_rsp_valid", LB'(b_rsp_valid), LB'(1));
            chk("b_rsp_id", LB'(b_rsp_id), LB'(qb[0].id));
            chk("b_rsp_data", b_rsp_data, qb[0].data);
            last_b = qb[0].data;
            void'(qb.pop_front());
        end else begin
            chk("b_rsp_idle", LB'(b_rsp_valid), LB'(0));
            chk("b_rsp_hold", b_rsp_data, last_b);
        end
        if (wr_req) shadow[wr_addr][int'(wr_slot)*PB +: PB] = wr_data;
        if (win >= 0) begin
            qa.push_back('{cyc + 2, win, shadow[raddr]});
            qb.push_back('{cyc + 3, win, shadow[raddr]});
            ptr = win;
        end
        last_win = win;
        @(posedge clk);
        #1;
        cyc++;
        if (drop && win >= 0) rd_req[win] = 1'b0;
    endtask

    task automatic idle_inputs();
        rd_req = '0;
        wr_req = 1'b0;
    endtask

    initial begin
        for (int l = 0; l < NUM_LEAVES; l++) shadow[l] = seed_leaf(l);
        model_reset();
        cyc     = 0;
        rst_n   = 1'b0;
        rd_req  = '0;
        rd_addr = '0;
        wr_req  = 1'b0;
        wr_addr = '0;
        wr_slot = '0;
        wr_data = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Idle after reset.
        repeat (10) do_cycle(1'b0);

        // Write leaf 3 slot 5, then lane 2 reads it back next cycle.
        wr_req  = 1'b1;
        wr_addr = AW'(3);
        wr_slot = 3'd5;
        wr_data = {PATCH_SIZE{11'h1AB}};
        do_cycle(1'b0);
        wr_req = 1'b0;
        rd_req = 4'b0100;
        rd_addr[2*AW +: AW] = AW'(3);
        do_cycle(1'b1);
        chk("wr_then_rd_lane", LB'(last_win), LB'(2));
        repeat (3) do_cycle(1'b0);
        chk("wr_then_rd_slot5", LB'(a_rsp_data[5*PB +: PB]), LB'({PATCH_SIZE{11'h1AB}}));

        // All lanes continuously from reset.
        reset_pulse();
        for (int l = 0; l < NR; l++) rd_addr[l*AW +: AW] = AW'(10 + l);
        rd_req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            do_cycle(1'b0);
            chk("rr_order", LB'(last_win), LB'(i % NR));
        end
        idle_inputs();
        repeat (4) do_cycle(1'b0);

        // Write held 3 cycles while lanes 1 and 3 wait.
        rd_req = 4'b1010;
        rd_addr[1*AW +: AW] = AW'(40);
        rd_addr[3*AW +: AW] = AW'(41);
        wr_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_addr = AW'(50 + i);
            wr_slot = 3'(i);
            wr_data = rand_patch();
            do_cycle(1'b1);
        end
        wr_req = 1'b0;
        do_cycle(1'b1);
        chk("after_wr_first", LB'(last_win), LB'(1));
        do_cycle(1'b1);
        chk("after_wr_second", LB'(last_win), LB'(3));
        repeat (4) do_cycle(1'b0);

        // Reset drops an in-flight read; afterwards lane 0 beats lane 2.
        rd_req = 4'b0100;
        rd_addr[2*AW +: AW] = AW'(20);
        do_cycle(1'b1);
        reset_pulse();
        repeat (4) do_cycle(1'b0);
        rd_req = 4'b0101;
        rd_addr[0] = 1'b1;
        do_cycle(1'b1);
        chk("post_rst_lane0", LB'(last_win), LB'(0));
        do_cycle(1'b1);
        repeat (4) do_cycle(1'b0);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            wr_req  = ($urandom_range(4) == 0);
            wr_addr = AW'($urandom);
            wr_slot = 3'($urandom);
            wr_data = rand_patch();
            for (int l = 0; l < NR; l++) begin
                if (!rd_req[l] && $urandom_range(2) == 0) begin
                    rd_req[l] = 1'b1;
                    rd_addr[l*AW +: AW] = AW'($urandom);
                end else if (rd_req[l] && $urandom_range(9) == 0) begin
                    rd_req[l] = 1'b0;
                end
            end
            if ($urandom_range(96) == 0) reset_pulse();
            do_cycle(1'b1);
        end
        idle_inputs();
        repeat (5) do_cycle(1'b0);
        chk("drained", LB'(qa.size() + qb.size()), LB'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
